// File: rtl/bus_arbiter_4to1_8b_pkg.sv
// rtl/bus_arbiter_4to1_8b_pkg.sv - shared constants for the 4-to-1 bus arbiter
// FSM state encoding, requester indices and the index-to-one-hot decode.
package bus_arbiter_4to1_8b_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_4to1_8b_rr_pick_4.sv
// rtl/bus_arbiter_4to1_8b_rr_pick_4.sv - combinational round-robin picker
// First set request bit at or after ptr, wrapping modulo 4.
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [7:0] dbl;
  logic [3:0] rot;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to requester ptr.
    dbl   = {req, req} >> ptr;
    rot   = dbl[3:0];
    found = |req;
    idx   = ptr;
    if (rot[0])      idx = ptr;
    else if (rot[1]) idx = ptr + 2'd1;
    else if (rot[2]) idx = ptr + 2'd2;
    else if (rot[3]) idx = ptr + 2'd3;
  end

endmodule

// File: rtl/mux_4to1_8b.sv
// rtl/mux_4to1_8b.sv - existing 8-bit 4-to-1 data mux
// Select pair {select2, select1}: 0=a, 1=b, 2=c, 3=d.
module MUX_4to1_8B (
  input  logic       select1,
  input  logic       select2,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  output logic [7:0] result
);

  always_comb begin
    case ({select2, select1})
      2'd0:    result = a;
      2'd1:    result = b;
      2'd2:    result = c;
      default: result = d;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_4to1_8b.sv
// rtl/bus_arbiter_4to1_8b.sv - round-robin burst arbiter for the shared 8-bit bus
// Grants one of four requesters, caps bursts at MAX_BURST beats, drives the data mux.
module bus_arbiter_4to1_8b
  import bus_arbiter_4to1_8b_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic       input_clk,
  input  logic       input_reset,
  input  logic [3:0] input_req,
  input  logic [7:0] input_a,
  input  logic [7:0] input_b,
  input  logic [7:0] input_c,
  input  logic [7:0] input_d,
  input  logic       input_ready,
  output logic       output_select1,
  output logic       output_select2,
  output logic [3:0] output_grant,
  output logic       output_valid,
  output logic [7:0] output_result,
  output logic [3:0] output_ack
);

  logic [0:0]       state;
  logic [1:0]       owner;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] count;

  logic       owner_req;
  logic       xfer;
  logic       last_beat;
  logic       release_now;
  logic [3:0] pick_req;
  logic [1:0] pick_ptr;
  logic       found;
  logic [1:0] pick_idx;

  always_comb begin
    owner_req    = input_req[owner];
    output_valid = (state == ST_GRANT) && owner_req;
    xfer         = output_valid && input_ready;
    last_beat    = (count == CNT_W'(MAX_BURST - 1));
    release_now  = (state == ST_GRANT) && (!owner_req || (xfer && last_beat));
    // On release the outgoing owner sits out this one decision.
    pick_req     = release_now ? (input_req & ~onehot4(owner)) : input_req;
    pick_ptr     = release_now ? (owner + 2'd1) : ptr;
    output_grant = (state == ST_GRANT) ? onehot4(owner) : 4'b0000;
    output_ack   = xfer ? onehot4(owner) : 4'b0000;
  end

  rr_pick_4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      state <= ST_IDLE;
      owner <= REQ_A;
      ptr   <= 2'd0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_GRANT;
            owner <= pick_idx;
          end
        end
        default: begin
          if (release_now) begin
            ptr   <= owner + 2'd1;
            count <= '0;
            if (found) owner <= pick_idx;
            else       state <= ST_IDLE;
          end else if (xfer) begin
            count <= count + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign output_select1 = owner[0];
  assign output_select2 = owner[1];

  MUX_4to1_8B u_mux (
    .select1 (output_select1),
    .select2 (output_select2),
    .a       (input_a),
    .b       (input_b),
    .c       (input_c),
    .d       (input_d),
    .result  (output_result)
  );

endmodule

// File: tb/tb_bus_arbiter_4to1_8b.sv
// tb/tb_bus_arbiter_4to1_8b.sv - self-checking bench for bus_arbiter_4to1_8b
// Two instances: MAX_BURST=4 and MAX_BURST=1, both compared to a reference model.
module tb_bus_arbiter_4to1_8b;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic       ready;

  logic       s1_0, s2_0, v0, s1_1, s2_1, v1;
  logic [3:0] g0, ack0, g1, ack1;
  logic [7:0] r0, r1;

  int pass_cnt = 0;
  int total    = 0;

  int m_busy [2];
  int m_own  [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_mb   [2] = '{4, 1};

  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] ack;
    logic [1:0] sel;
    logic [7:0] result;
  } vec_t;

  vec_t tbl [7];

  bus_arbiter_4to1_8b #(.MAX_BURST(4), .CNT_W(8)) dut (
    .input_clk(clk), .input_reset(rst), .input_req(req),
    .input_a(a), .input_b(b), .input_c(c), .input_d(d), .input_ready(ready),
    .output_select1(s1_0), .output_select2(s2_0), .output_grant(g0),
    .output_valid(v0), .output_result(r0), .output_ack(ack0)
  );

  bus_arbiter_4to1_8b #(.MAX_BURST(1), .CNT_W(8)) dut1 (
    .input_clk(clk), .input_reset(rst), .input_req(req),
    .input_a(a), .input_b(b), .input_c(c), .input_d(d), .input_ready(ready),
    .output_select1(s1_1), .output_select2(s2_1), .output_grant(g1),
    .output_valid(v1), .output_result(r1), .output_ack(ack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int search(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] data_of(input int idx);
    case (idx)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_own[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cycle(input logic [3:0] rq, input logic rdy, input logic rs);
    logic [3:0] eg, ea;
    logic       ev, tx;
    int         s;
    @(negedge clk);
    req = rq; ready = rdy; rst = rs;
    #1;
    for (int i = 0; i < 2; i++) begin
      eg = m_busy[i] ? (4'b0001 << m_own[i]) : 4'b0000;
      ev = m_busy[i] && rq[m_own[i]];
      ea = (ev && rdy) ? (4'b0001 << m_own[i]) : 4'b0000;
      check($sformatf("grant%0d", i), {4'b0, (i == 0) ? g0 : g1}, {4'b0, eg});
      check($sformatf("valid%0d", i), {7'b0, (i == 0) ? v0 : v1}, {7'b0, ev});
      check($sformatf("ack%0d", i), {4'b0, (i == 0) ? ack0 : ack1}, {4'b0, ea});
      check($sformatf("sel%0d", i), {6'b0, (i == 0) ? {s2_0, s1_0} : {s2_1, s1_1}},
            8'(m_own[i]));
      check($sformatf("result%0d", i), (i == 0) ? r0 : r1, data_of(m_own[i]));
    end
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        m_busy[i] = 0; m_own[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
      end else if (m_busy[i] == 0) begin
        s = search(rq, m_ptr[i]);
        if (s >= 0) begin m_busy[i] = 1; m_own[i] = s; end
      end else begin
        tx = rq[m_own[i]] && rdy;
        if (!rq[m_own[i]] || (tx && (m_cnt[i] + 1 == m_mb[i]))) begin
          m_ptr[i] = (m_own[i] + 1) % 4;
          m_cnt[i] = 0;
          s = search(rq & ~(4'b0001 << m_own[i]), m_ptr[i]);
          if (s >= 0) m_own[i] = s;
          else        m_busy[i] = 0;
        end else if (tx) begin
          m_cnt[i]++;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1; req = 4'b0; ready = 1'b0;
    a = 8'h3C; b = 8'h5A; c = 8'hC3; d = 8'hA5;
    repeat (2) @(posedge clk);
    model_reset();

    // Single requester A: reset state, 4-beat burst, bubble, re-grant.
    tbl[0] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 8'h3C};
    for (int i = 1; i <= 4; i++)
      tbl[i] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 8'h3C};
    tbl[5] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 8'h3C};
    tbl[6] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 8'h3C};
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].req, tbl[i].ready, 1'b0);
      check($sformatf("tbl%0d_grant", i), {4'b0, g0}, {4'b0, tbl[i].grant});
      check($sformatf("tbl%0d_valid", i), {7'b0, v0}, {7'b0, tbl[i].valid});
      check($sformatf("tbl%0d_ack", i), {4'b0, ack0}, {4'b0, tbl[i].ack});
      check($sformatf("tbl%0d_sel", i), {6'b0, s2_0, s1_0}, {6'b0, tbl[i].sel});
      check($sformatf("tbl%0d_result", i), r0, tbl[i].result);
    end

    // All four requesting: A4 B4 C4 D4 then A, no idle between owners.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b1111, 1'b1, 1'b0);
    check("rr_first_idle", {4'b0, g0}, 8'h00);
    for (int k = 0; k < 17; k++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      exp_g = (k < 16) ? (4'b0001 << (k / 4)) : 4'b0001;
      check($sformatf("rr_seq%0d", k), {4'b0, g0}, {4'b0, exp_g});
    end

    // Backpressure on B: everything holds, count resumes afterwards.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0010, 1'b0, 1'b0);
      check("bp_grant", {4'b0, g0}, 8'h02);
      check("bp_sel", {6'b0, s2_0, s1_0}, 8'h01);
      check("bp_ack", {4'b0, ack0}, 8'h00);
    end
    repeat (3) cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);
    check("bp_burst_end", {4'b0, g0}, 8'h00);

    // Early release by C with A and D waiting: D then A.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0100, 1'b1, 1'b0);
    repeat (2) cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0);
    check("early_c_valid", {7'b0, v0}, 8'h00);
    cycle(4'b1001, 1'b1, 1'b0);
    check("early_d", {4'b0, g0}, 8'h08);
    repeat (3) cycle(4'b1001, 1'b1, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0);
    check("early_a", {4'b0, g0}, 8'h01);

    // Reset during D's third beat.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b1000, 1'b1, 1'b0);
    repeat (2) cycle(4'b1000, 1'b1, 1'b0);
    cycle(4'b1000, 1'b1, 1'b1);
    cycle(4'b1001, 1'b1, 1'b0);
    check("mid_rst_grant", {4'b0, g0}, 8'h00);
    check("mid_rst_sel", {6'b0, s2_0, s1_0}, 8'h00);
    check("mid_rst_valid", {7'b0, v0}, 8'h00);
    cycle(4'b1001, 1'b1, 1'b0);
    check("mid_rst_a_wins", {4'b0, g0}, 8'h01);

    // MAX_BURST=1 instance: B and C alternate, one ack each.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0110, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b0110, 1'b1, 1'b0);
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b0100;
      check($sformatf("mb1_grant%0d", k), {4'b0, g1}, {4'b0, exp_g});
      check($sformatf("mb1_ack%0d", k), {4'b0, ack1}, {4'b0, exp_g});
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      cycle(4'($urandom_range(0, 15)), ($urandom % 4) != 0, ($urandom % 64) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
